// File: rtl/scr1_memif_pkg.sv
// Memory-interface enums shared by the core data path and its bridges.
package scr1_memif_pkg;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'd0,
        SCR1_MEM_WIDTH_HWORD = 2'd1,
        SCR1_MEM_WIDTH_WORD  = 2'd2,
        SCR1_MEM_WIDTH_ERROR = 2'd3
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'd0,
        SCR1_MEM_RESP_RDY_OK = 2'd1,
        SCR1_MEM_RESP_RDY_ER = 2'd2
    } type_scr1_mem_resp_e;

endpackage

// File: rtl/scr1_tcm_lane_align.sv
// Byte-lane steering: write enables/data toward the TCM, right-aligned read data back.
module scr1_tcm_lane_align
    import scr1_memif_pkg::*;
(
    input  logic [1:0]  req_width_i,
    input  logic [1:0]  req_off_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  rsp_width_i,
    input  logic [1:0]  rsp_off_i,
    input  logic [31:0] qb_i,
    output logic [3:0]  webb_o,
    output logic [31:0] datab_o,
    output logic [31:0] rdata_o
);

    localparam logic [3:0]  LANE_B = 4'b0001;
    localparam logic [3:0]  LANE_H = 4'b0011;
    localparam logic [3:0]  LANE_W = 4'b1111;
    localparam logic [31:0] MASK_B = 32'h0000_00FF;
    localparam logic [31:0] MASK_H = 32'h0000_FFFF;

    logic [31:0] qb_shift;

    always_comb begin
        webb_o = 4'b0000;
        case (req_width_i)
            SCR1_MEM_WIDTH_BYTE:  webb_o = LANE_B << req_off_i;
            SCR1_MEM_WIDTH_HWORD: webb_o = LANE_H << req_off_i;
            SCR1_MEM_WIDTH_WORD:  webb_o = LANE_W;
            default:              webb_o = 4'b0000;
        endcase
    end

    assign datab_o  = wdata_i << {req_off_i, 3'b000};
    assign qb_shift = qb_i >> {rsp_off_i, 3'b000};

    always_comb begin
        rdata_o = 32'h0;
        case (rsp_width_i)
            SCR1_MEM_WIDTH_BYTE:  rdata_o = qb_shift & MASK_B;
            SCR1_MEM_WIDTH_HWORD: rdata_o = qb_shift & MASK_H;
            SCR1_MEM_WIDTH_WORD:  rdata_o = qb_shift;
            default:              rdata_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/scr1_tcm_dmem_bridge.sv
// Core dmem handshake to TCM port-B bridge. Define SCR1_TCM_BRIDGE_RESP_REG_EN to
// register dmem_resp/dmem_rdata (two-cycle latency, one transaction outstanding).
module scr1_tcm_dmem_bridge
    import scr1_memif_pkg::*;
#(
    parameter int          SCR1_WIDTH    = 32,
    parameter logic [31:0] SCR1_SIZE     = 32'h0001_0000,
    parameter logic [31:0] SCR1_TCM_BASE = 32'hF000_0000,
    localparam int         AW            = $clog2(SCR1_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dmem_req,
    input  logic                  dmem_cmd,
    input  logic [1:0]            dmem_width,
    input  logic [31:0]           dmem_addr,
    input  logic [SCR1_WIDTH-1:0] dmem_wdata,
    output logic                  dmem_req_ack,
    output logic [SCR1_WIDTH-1:0] dmem_rdata,
    output logic [1:0]            dmem_resp,
    output logic                  renb,
    output logic                  wenb,
    output logic [3:0]            webb,
    output logic [AW-3:0]         addrb,
    output logic [SCR1_WIDTH-1:0] datab,
    input  logic [SCR1_WIDTH-1:0] qb
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RESP = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
`ifdef SCR1_TCM_BRIDGE_RESP_REG_EN
    localparam logic [1:0] ST_CAPT = ST_WAIT;
`else
    localparam logic [1:0] ST_CAPT = ST_RESP;
`endif

    logic [1:0]  state_q, state_d;
    logic        ready_q, pend_q, cmd_q, err_q;
    logic [1:0]  width_q, off_q;
    logic        accept, req_err;
    logic [3:0]  lane_webb;
    logic [31:0] lane_datab, lane_rdata;
    logic [1:0]  resp_d;
    logic [31:0] rdata_d;

    assign req_err = (dmem_addr[31:AW] != SCR1_TCM_BASE[31:AW])
                   | (dmem_width == SCR1_MEM_WIDTH_ERROR)
                   | ((dmem_width == SCR1_MEM_WIDTH_HWORD) & dmem_addr[0])
                   | ((dmem_width == SCR1_MEM_WIDTH_WORD) & (dmem_addr[1:0] != 2'b00));

`ifdef SCR1_TCM_BRIDGE_RESP_REG_EN
    assign dmem_req_ack = ready_q & (state_q != ST_WAIT);
`else
    assign dmem_req_ack = ready_q;
`endif
    assign accept = dmem_req & dmem_req_ack;

    scr1_tcm_lane_align u_align (
        .req_width_i (dmem_width),
        .req_off_i   (dmem_addr[1:0]),
        .wdata_i     (dmem_wdata),
        .rsp_width_i (width_q),
        .rsp_off_i   (off_q),
        .qb_i        (qb),
        .webb_o      (lane_webb),
        .datab_o     (lane_datab),
        .rdata_o     (lane_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b0;
            pend_q  <= 1'b0;
            cmd_q   <= 1'b0;
            err_q   <= 1'b0;
            width_q <= 2'd0;
            off_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            ready_q <= 1'b1;
            pend_q  <= accept;
            if (accept) begin
                cmd_q   <= dmem_cmd;
                err_q   <= req_err;
                width_q <= dmem_width;
                off_q   <= dmem_addr[1:0];
            end
        end
    end

    always_comb begin
        state_d = ST_IDLE;
`ifdef SCR1_TCM_BRIDGE_RESP_REG_EN
        case (state_q)
            ST_IDLE: state_d = accept ? ST_WAIT : ST_IDLE;
            ST_WAIT: state_d = ST_RESP;
            ST_RESP: state_d = accept ? ST_WAIT : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
`else
        state_d = accept ? ST_RESP : ST_IDLE;
`endif
    end

    always_comb begin
        renb    = accept & ~req_err & (dmem_cmd == SCR1_MEM_CMD_RD);
        wenb    = accept & ~req_err & (dmem_cmd == SCR1_MEM_CMD_WR);
        webb    = wenb ? lane_webb : 4'b0000;
        datab   = wenb ? lane_datab : '0;
        addrb   = (renb | wenb) ? dmem_addr[AW-1:2] : '0;
        resp_d  = SCR1_MEM_RESP_NOTRDY;
        rdata_d = 32'h0;
        // ST_CAPT is the cycle qb is valid for the accepted request
        if (pend_q && (state_q == ST_CAPT)) begin
            resp_d = err_q ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
            if (!err_q && (cmd_q == SCR1_MEM_CMD_RD))
                rdata_d = lane_rdata;
        end
    end

`ifdef SCR1_TCM_BRIDGE_RESP_REG_EN
    logic [1:0]  resp_q;
    logic [31:0] rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_q  <= SCR1_MEM_RESP_NOTRDY;
            rdata_q <= 32'h0;
        end else begin
            resp_q  <= resp_d;
            rdata_q <= rdata_d;
        end
    end

    assign dmem_resp  = resp_q;
    assign dmem_rdata = rdata_q;
`else
    assign dmem_resp  = resp_d;
    assign dmem_rdata = rdata_d;
`endif

endmodule

// File: tb/tb_scr1_tcm_dmem_bridge.sv
// Directed bench for scr1_tcm_dmem_bridge with a behavioural TCM port-B model.
module tb_scr1_tcm_dmem_bridge;

    localparam logic [31:0] BASE = 32'hF000_0000;
`ifdef SCR1_TCM_BRIDGE_RESP_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dmem_req = 1'b0;
    logic        dmem_cmd = 1'b0;
    logic [1:0]  dmem_width = 2'd0;
    logic [31:0] dmem_addr = 32'h0;
    logic [31:0] dmem_wdata = 32'h0;
    logic        dmem_req_ack;
    logic [31:0] dmem_rdata;
    logic [1:0]  dmem_resp;
    logic        renb, wenb;
    logic [3:0]  webb;
    logic [13:0] addrb;
    logic [31:0] datab;
    logic [31:0] qb = 32'h0;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:16383];

    always #5 clk = ~clk;

    scr1_tcm_dmem_bridge dut (
        .clk(clk), .rst(rst),
        .dmem_req(dmem_req), .dmem_cmd(dmem_cmd), .dmem_width(dmem_width),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_req_ack(dmem_req_ack), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .renb(renb), .wenb(wenb), .webb(webb), .addrb(addrb), .datab(datab), .qb(qb)
    );

    always @(posedge clk) begin
        if (wenb)
            for (int b = 0; b < 4; b++)
                if (webb[b]) mem[addrb][8*b +: 8] <= datab[8*b +: 8];
        if (renb) qb <= mem[addrb];
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // drive a request at edge+1; strobes are settled on return
    task automatic issue(input logic cmd, input logic [1:0] w, input logic [31:0] a,
                         input logic [31:0] wd);
        dmem_req = 1'b1; dmem_cmd = cmd; dmem_width = w; dmem_addr = a; dmem_wdata = wd;
        #1;
    endtask

    // advance to the response cycle with req dropped
    task automatic to_resp();
        @(posedge clk); #1;
        dmem_req = 1'b0;
        for (int i = 1; i < LAT; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic chk_resp(input string tag, input logic [1:0] rsp, input logic [31:0] rd);
        chk({tag, "_resp"}, {30'h0, dmem_resp}, {30'h0, rsp});
        chk({tag, "_rdata"}, dmem_rdata, rd);
    endtask

    logic [31:0] b2b_exp [4];

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 32'h0;

        #12;
        chk("rst_ack", {31'h0, dmem_req_ack}, 32'h0);
        chk_resp("rst", 2'd0, 32'h0);
        chk("rst_strb", {renb, wenb, webb, datab[3:0]}, 10'h0);
        chk("rst_addrb", {18'h0, addrb}, 32'h0);
        chk("rst_datab", datab, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("ack_after_rst", {31'h0, dmem_req_ack}, 32'h1);

        // word write then read
        issue(1'b1, 2'd2, BASE + 32'h8, 32'hDEAD_BEEF);
        chk("ww_en", {renb, wenb, webb}, 6'b01_1111);
        chk("ww_addrb", {18'h0, addrb}, 32'h2);
        chk("ww_datab", datab, 32'hDEAD_BEEF);
        to_resp();
        chk_resp("ww", 2'd1, 32'h0);
        issue(1'b0, 2'd2, BASE + 32'h8, 32'h0);
        chk("wr_en", {renb, wenb, webb}, 6'b10_0000);
        chk("wr_addrb", {18'h0, addrb}, 32'h2);
        to_resp();
        chk_resp("wr", 2'd1, 32'hDEAD_BEEF);

        // byte write lane 3, then byte and halfword reads
        issue(1'b1, 2'd0, BASE + 32'hB, 32'h0000_00A5);
        chk("bw_webb", {28'h0, webb}, 32'h8);
        chk("bw_datab", datab, 32'hA500_0000);
        to_resp();
        chk_resp("bw", 2'd1, 32'h0);
        issue(1'b0, 2'd0, BASE + 32'hB, 32'h0);
        to_resp();
        chk_resp("br", 2'd1, 32'h0000_00A5);
        issue(1'b0, 2'd1, BASE + 32'hA, 32'h0);
        to_resp();
        chk_resp("hr", 2'd1, 32'h0000_A5AD);

        // halfword write upper lanes, checked by word read
        issue(1'b1, 2'd1, BASE + 32'h2, 32'h0000_1234);
        chk("hw_webb", {28'h0, webb}, 32'hC);
        chk("hw_datab", datab, 32'h1234_0000);
        to_resp();
        chk_resp("hw", 2'd1, 32'h0);
        issue(1'b1, 2'd2, BASE + 32'h4, 32'h0000_4444);
        to_resp();
        issue(1'b1, 2'd2, BASE + 32'hC, 32'hC0C0_C0C0);
        to_resp();

        // error cases
        issue(1'b0, 2'd1, BASE + 32'h1, 32'h0);
        chk("mis_en", {30'h0, renb, wenb}, 32'h0);
        to_resp();
        chk_resp("mis", 2'd2, 32'h0);
        issue(1'b0, 2'd2, 32'h0000_1000, 32'h0);
        chk("oor_en", {30'h0, renb, wenb}, 32'h0);
        to_resp();
        chk_resp("oor", 2'd2, 32'h0);
        issue(1'b1, 2'd3, BASE, 32'hFFFF_FFFF);
        chk("w3_en", {renb, wenb, webb}, 6'h0);
        to_resp();
        chk_resp("w3", 2'd2, 32'h0);
        issue(1'b0, 2'd2, BASE + 32'h2, 32'h0);
        to_resp();
        chk_resp("wmis", 2'd2, 32'h0);

        // back-to-back reads with req held
        b2b_exp[0] = 32'h1234_0000; b2b_exp[1] = 32'h0000_4444;
        b2b_exp[2] = 32'hA5AD_BEEF; b2b_exp[3] = 32'hC0C0_C0C0;
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, 2'd2, BASE + 32'(4 * i), 32'h0);
            chk("b2b_ack", {31'h0, dmem_req_ack}, 32'h1);
            @(posedge clk); #1;
`ifdef SCR1_TCM_BRIDGE_RESP_REG_EN
            chk("b2b_ack_wait", {31'h0, dmem_req_ack}, 32'h0);
            @(posedge clk); #1;
`endif
            chk_resp("b2b", 2'd1, b2b_exp[i]);
        end
        dmem_req = 1'b0;
        @(posedge clk); #1;
        chk("b2b_idle", {30'h0, dmem_resp}, 32'h0);

        // reset in the cycle after a read is accepted
        issue(1'b0, 2'd2, BASE + 32'h8, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1; dmem_req = 1'b0;
        #1;
        chk_resp("rstmid", 2'd0, 32'h0);
        chk("rstmid_ack", {31'h0, dmem_req_ack}, 32'h0);
        chk("rstmid_strb", {renb, wenb, webb, addrb, datab}, 52'h0);
        @(posedge clk); #1;
        chk_resp("rstmid2", 2'd0, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk_resp("rstmid3", 2'd0, 32'h0);
        chk("rstrel_ack", {31'h0, dmem_req_ack}, 32'h1);
        issue(1'b0, 2'd2, BASE + 32'h8, 32'h0);
        to_resp();
        chk_resp("after_rst", 2'd1, 32'hA5AD_BEEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: sim time %0t want completion", $time);
        $fatal(1);
    end

endmodule

// File: doc/scr1_tcm_dmem_bridge.md
# scr1_tcm_dmem_bridge

Initiator-side controller for the TCM dual-port memory: converts the core data-memory request/response handshake into port-B strobes of the synchronous TCM array and returns lane-aligned read data. Sits between the LSU data-memory router and the TCM memory. It handles the following:
- address range check;
- misalignment errors;
- byte-enable generation;
- write-data steering;
- read-data extraction.

## Interface
Parameters:
- SCR1_WIDTH, 32, memory word width (bits); only 32 supported
- SCR1_SIZE, 32'h00010000, TCM size in bytes (power of two); AW = $clog2(SCR1_SIZE)
- SCR1_TCM_BASE, 32'hF0000000, TCM base address, aligned to SCR1_SIZE

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- dmem_req  in  1  core request valid
- dmem_cmd  in  1  0 = read, 1 = write
- dmem_width  in  2  0 = byte, 1 = halfword, 2 = word, 3 = reserved
- dmem_addr  in  32  byte address
- dmem_wdata  in  32  write data, right-aligned (byte in [7:0], halfword in [15:0])
- dmem_req_ack  out  1  request accepted this cycle when dmem_req & dmem_req_ack
- dmem_rdata  out  32  read data, right-aligned, zero-extended
- dmem_resp  out  2  0 = NOTRDY, 1 = RDY_OK, 2 = RDY_ER
- renb  out  1  memory read strobe
- wenb  out  1  memory write strobe
- webb  out  4  memory byte enables
- addrb  out  AW-2  memory word address, dmem_addr[AW-1:2]
- datab  out  32  memory write data, lane-steered
- qb  in  32  memory read data, valid the cycle after renb

## Operation
- **Acceptance:** a request is accepted at cycle T when dmem_req & dmem_req_ack.
- **Error checks:** an accepted request is an error if any of the following holds. Errors never assert renb or wenb.
  - dmem_addr[31:AW] != SCR1_TCM_BASE[31:AW];
  - width = 3;
  - halfword with addr[0] = 1;
  - word with addr[1:0] != 0.
- **Memory strobes:** renb, wenb, webb, addrb and datab are combinational from the request in cycle T, gated by acceptance.
  - Read: renb = 1.
  - Write: wenb = 1 and renb = 0.
- **Byte enables:** off = addr[1:0].
  - byte: webb = 4'b0001 << off
  - halfword: webb = 4'b0011 << off
  - word: webb = 4'b1111
- **Write data:** datab = dmem_wdata << (8*off). datab is don't-care when wenb = 0 (drive 0).
- **Response state:** at cycle T the bridge registers the following into response state (FSM IDLE -> RESP):
  - a pending flag;
  - cmd, width and off;
  - an error flag.
- **Read data extraction:** rdata = qb >> (8*off), then masked to width.
  - byte: {24'h0, byte}
  - halfword: {16'h0, halfword}
  - word: full 32 bits
- **Write or error responses:** dmem_rdata = 0.
- **Response code:** dmem_resp = RDY_OK, or RDY_ER if the error flag is set, for exactly one cycle. Otherwise NOTRDY.
- **FSM** (states IDLE, RESP):
  - IDLE -> RESP on acceptance.
  - RESP -> RESP on a back-to-back acceptance.
  - RESP -> IDLE otherwise.
- **Reset:** asserting rst at any time forces IDLE and clears pending. A response in flight is dropped; no response is issued for it.

## Timing
- **Reset values:**
  - dmem_req_ack = 0, dmem_resp = NOTRDY, dmem_rdata = 0;
  - renb = 0, wenb = 0, webb = 0, addrb = 0, datab = 0.
- **dmem_req_ack:** 1 from the first cycle after rst deasserts.
- **Latency:** the response appears at T+1.
- **Throughput:** one request per cycle, back-to-back.
- **Read-after-write to the same word at T, T+1:** the read at T+1 returns the data written at T (the memory is write-then-read across cycles).
- **Hold-off:** dmem_req_ack has no other hold-off in the base configuration.

## Configuration
- **SCR1_TCM_BRIDGE_RESP_REG_EN defined:** adds an output register on dmem_resp/dmem_rdata.
  - qb is captured at T+1; the response appears at T+2.
  - One transaction outstanding: dmem_req_ack = 0 in T+1 and returns to 1 in T+2.
  - FSM gains state WAIT: IDLE -> WAIT -> RESP -> IDLE, or RESP -> WAIT on acceptance in RESP.
  - The response register resets to NOTRDY / 0.
- **Undefined:** single-cycle latency, full throughput, two-state FSM as above.

## Structure
- **Shared package:** the memory-interface enums (cmd, width, resp codes) come from the shared scr1_memif_pkg; no new typedefs.
- **Local constants:** the lane-mask constants are local.
- **Sub-module scr1_tcm_lane_align** (combinational):
  - webb/datab generation from width and off;
  - rdata extraction from qb, width and off.
- **FSM and response registers** stay in the top.

## Test plan
- **Word write/read:** write word 32'hDEADBEEF at SCR1_TCM_BASE+8, then read the same address. Required:
  - write: wenb = 1, webb = 4'hF, addrb = 2;
  - write response: RDY_OK at T+1;
  - read response: RDY_OK with rdata = 32'hDEADBEEF at T+1 of the read.
- **Byte write/read:** write byte 8'hA5 at BASE+0x0B. Required: webb = 4'b1000, datab = 32'hA5000000. A subsequent byte read at BASE+0x0B returns rdata = 32'h000000A5.
- **Misalignment:** halfword read at BASE+0x01. Required: renb = 0, RDY_ER at T+1, rdata = 0.
- **Out of range:** word read at 32'h00001000. Required: renb = 0, RDY_ER at T+1, rdata = 0.
- **Back-to-back:** four consecutive reads of BASE+0, +4, +8, +C with req held high. Required: req_ack = 1 every cycle, four RDY_OK responses in consecutive cycles, in order. With SCR1_TCM_BRIDGE_RESP_REG_EN defined: req_ack alternates 1/0 and responses arrive at T+2.
- **Reset mid-read:** assert rst in the cycle after a read is accepted. Required: dmem_resp stays NOTRDY, all outputs return to reset values, the next request after release completes normally.
